// File: rtl/fc_layer_sched.sv
// fc_layer_sched: runs one shared 30-input FC neuron engine over all N_OUT
// output neurons of a layer. Per neuron it fetches the weight row and bias,
// pulses the engine start, and captures the result. Each result is streamed
// out, and a running signed argmax gives the classification index.
//
// Build option: define FC_SCHED_RELU_EN to clamp negative engine results to
// zero before they are streamed and compared.
//
// Handshakes: o_fetch_req is a level held for the whole FETCH state, and
// i_fetch_valid is only looked at while it is high; one high sample completes
// the fetch. o_fc_start is a single-cycle pulse, and i_fc_finished is only
// looked at in WAIT; one high sample delivers i_fc_output. o_result_valid and
// o_done are single-cycle pulses with no back-pressure. i_start is only
// accepted in IDLE.
module fc_layer_sched #(
  parameter int N_OUT       = 8,
  parameter int IDX_W       = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_fetch_req,
  output logic [IDX_W-1:0]  o_neuron_idx,
  input  logic              i_fetch_valid,
  output logic              o_fc_start,
  input  logic              i_fc_finished,
  input  logic [31:0]       i_fc_output,
  output logic              o_result_valid,
  output logic [IDX_W-1:0]  o_result_idx,
  output logic [31:0]       o_result_data,
  output logic              o_done,
  output logic [IDX_W-1:0]  o_class,
  output logic [31:0]       o_max,
  output logic              o_error,
  output logic [2:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic signed [31:0]    r_result;
  logic signed [31:0]    r_max;
  logic [IDX_W-1:0]      r_class;
  logic                  r_error;
  logic signed [31:0]    w_fc_val;
  logic                  w_last;
  logic                  w_timeout;

`ifdef FC_SCHED_RELU_EN
  // Negative engine results are clamped so both the stream and argmax see 0.
  assign w_fc_val = i_fc_output[31] ? 32'sd0 : $signed(i_fc_output);
`else
  assign w_fc_val = $signed(i_fc_output);
`endif

  assign w_last    = (r_idx == LAST_IDX);
  // This is the last WAIT cycle allowed; no finish here means abort.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; inputs outside their owning state are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_FETCH;
      S_FETCH: if (i_fetch_valid) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (i_fc_finished)  w_next = S_STORE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_STORE: w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: neuron index, wait counter, result capture, running argmax, error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_max    <= '0;
      r_class  <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx   <= '0;
            r_max   <= 32'sh8000_0000;
            r_class <= '0;
            r_error <= 1'b0;
          end
        end
        S_START: r_cnt <= '0;
        S_WAIT: begin
          if (i_fc_finished)  r_result <= w_fc_val;
          else if (w_timeout) r_error  <= 1'b1;
          else                r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_STORE: begin
          // Strict compare so ties keep the earlier (lower) index.
          if (r_result > r_max) begin
            r_max   <= r_result;
            r_class <= r_idx;
          end
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode from the current state and the datapath registers.
  always_comb begin
    o_busy         = (r_state != S_IDLE);
    o_fetch_req    = (r_state == S_FETCH);
    o_fc_start     = (r_state == S_START);
    o_result_valid = (r_state == S_STORE);
    o_done         = (r_state == S_DONE);
    o_neuron_idx   = r_idx;
    o_result_idx   = r_idx;
    o_result_data  = r_result;
    o_class        = r_class;
    o_max          = r_max;
    o_error        = r_error;
    o_dbg_state    = r_state;
  end

endmodule

// File: tb/tb_fc_layer_sched.sv
// Bench for fc_layer_sched: table-driven layer passes, hand-written corner
// sequences (timeout, mid-pass reset, idle input noise) and random passes
// checked against a reference model of the layer.
module tb_fc_layer_sched;

  localparam int N     = 8;
  localparam int IW    = 3;

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic            i_fetch_valid = 1'b0;
  logic            i_fc_finished = 1'b0;
  logic [31:0]     i_fc_output = '0;
  logic            o_busy, o_fetch_req, o_fc_start, o_result_valid, o_done, o_error;
  logic [IW-1:0]   o_neuron_idx, o_result_idx, o_class;
  logic [31:0]     o_result_data, o_max;
  logic [2:0]      o_dbg_state;

  fc_layer_sched #(.N_OUT(N), .IDX_W(IW), .TIMEOUT_CYC(15)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
    .o_fetch_req(o_fetch_req), .o_neuron_idx(o_neuron_idx),
    .i_fetch_valid(i_fetch_valid), .o_fc_start(o_fc_start),
    .i_fc_finished(i_fc_finished), .i_fc_output(i_fc_output),
    .o_result_valid(o_result_valid), .o_result_idx(o_result_idx),
    .o_result_data(o_result_data), .o_done(o_done), .o_class(o_class),
    .o_max(o_max), .o_error(o_error), .o_dbg_state(o_dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][31:0] vals;
    int                 dly_n;
    int                 dly;
    logic [IW-1:0]      exp_cls;
    logic [31:0]        exp_max;
    int                 exp_cyc;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [IW+31:0] exp_q[$];

  // Environment state shared by the driver tasks.
  logic [N-1:0][31:0] eng_vals;
  int  eng_lat = 2;
  int  eng_cnt = -1;
  int  eng_idx = 0;
  int  hang_n  = -1;
  int  fetch_delay[N];
  int  fetch_seen = 0;
  int  cyc = 0;
  int  rv_count = 0;
  int  done_count = 0;
  int  done_cyc = 0;
  int  start1_cyc = 0;
  logic [IW-1:0] done_cls;
  logic [31:0]   done_max;

  int b_mix[N] = '{-5, 3, 10, 10, -1, 7, 2, 0};
  int b_neg[N] = '{-8, -7, -6, -5, -4, -3, -2, -1};
  int b_asc[N] = '{1, 2, 3, 4, 5, 6, 7, 8};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] relu_model(input logic [31:0] v);
`ifdef FC_SCHED_RELU_EN
    return ($signed(v) < 0) ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  // Argmax: the largest signed value, then the first index holding it.
  // An initial "most negative" max means a layer of all 0x80000000 gives 0.
  function automatic void ref_argmax(input logic [N-1:0][31:0] v,
                                     output logic [IW-1:0] c, output logic [31:0] m);
    logic signed [31:0] best;
    best = 32'sh8000_0000;
    for (int i = 0; i < N; i++)
      if ($signed(relu_model(v[i])) > best) best = $signed(relu_model(v[i]));
    m = best;
    c = '0;
    for (int i = N - 1; i >= 0; i--)
      if (relu_model(v[i]) == m) c = IW'(i);
  endfunction

  function automatic logic [N-1:0][31:0] shl8(input int b[N]);
    logic [N-1:0][31:0] r;
    for (int i = 0; i < N; i++) r[i] = 32'(b[i] * 256);
    return r;
  endfunction

  // One clock: sample outputs after the edge, score them, then drive the
  // parameter-store and engine models for the next edge.
  task automatic step();
    logic [IW+31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(o_result_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("result_idx", 32'(o_result_idx), 32'(e[IW+31:32]));
        check("result_data", o_result_data, e[31:0]);
      end
    end
    if (o_done) begin
      done_count++;
      done_cyc = cyc;
      done_cls = o_class;
      done_max = o_max;
    end
    i_fetch_valid = 1'b0;
    if (o_fetch_req) begin
      if (fetch_seen >= fetch_delay[o_neuron_idx]) i_fetch_valid = 1'b1;
      fetch_seen++;
    end else begin
      fetch_seen = 0;
    end
    i_fc_finished = 1'b0;
    i_fc_output   = $urandom();
    if (o_fc_start) begin
      eng_idx = int'(o_neuron_idx);
      if (eng_idx == 1) start1_cyc = cyc;
      eng_cnt = (hang_n == eng_idx) ? -1 : eng_lat;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        i_fc_finished = 1'b1;
        i_fc_output   = eng_vals[eng_idx];
        eng_cnt       = -1;
      end
    end
  endtask

  task automatic setup_pass(input logic [N-1:0][31:0] vals, input int lat, input int n_exp);
    eng_vals = vals;
    eng_lat  = lat;
    eng_cnt  = -1;
    rv_count = 0;
    done_count = 0;
    exp_q.delete();
    for (int i = 0; i < n_exp; i++) exp_q.push_back({IW'(i), relu_model(vals[i])});
  endtask

  task automatic run_pass(input string tag, input logic [N-1:0][31:0] vals, input int lat,
                          input bit spam, input logic [IW-1:0] exp_cls,
                          input logic [31:0] exp_max, input int exp_cyc);
    setup_pass(vals, lat, N);
    hang_n  = -1;
    i_start = 1'b1;
    cyc     = 1;
    step();
    i_start = 1'b0;
    check({tag, "_error_clear"}, 32'(o_error), 32'd0);
    for (int k = 0; k < 600 && done_count == 0; k++) begin
      step();
      i_start = (spam && o_busy && done_count == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    i_start = 1'b0;
    if (done_count == 0) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    check({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_cyc));
    check({tag, "_class"}, 32'(done_cls), 32'(exp_cls));
    check({tag, "_max"}, done_max, exp_max);
    check({tag, "_results"}, 32'(rv_count), 32'(N));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    check({tag, "_single_done"}, 32'(done_count), 32'd1);
    check({tag, "_idle_after"}, 32'(o_busy), 32'd0);
    check({tag, "_class_hold"}, 32'(o_class), 32'(exp_cls));
    check({tag, "_max_hold"}, o_max, exp_max);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_fetch_req"}, 32'(o_fetch_req), 32'd0);
    check({tag, "_fc_start"}, 32'(o_fc_start), 32'd0);
    check({tag, "_result_valid"}, 32'(o_result_valid), 32'd0);
    check({tag, "_done"}, 32'(o_done), 32'd0);
    check({tag, "_neuron_idx"}, 32'(o_neuron_idx), 32'd0);
    check({tag, "_result_idx"}, 32'(o_result_idx), 32'd0);
    check({tag, "_result_data"}, o_result_data, 32'd0);
    check({tag, "_class"}, 32'(o_class), 32'd0);
    check({tag, "_max"}, o_max, 32'd0);
    check({tag, "_error"}, 32'(o_error), 32'd0);
  endtask

  initial begin
    vec_t tbl[5];
    logic [N-1:0][31:0] v;
    logic [IW-1:0] mc;
    logic [31:0]   mm;
    int            ecyc;
    int            rv0;
    int            dc0;
    logic [31:0]   last_max;
    logic [IW-1:0] last_cls;

    for (int i = 0; i < N; i++) fetch_delay[i] = 0;

    // Known-answer table.
    tbl[0] = '{vals: shl8(b_mix), dly_n: -1, dly: 0, exp_cls: 3'd2, exp_max: 32'h0000_0A00, exp_cyc: 42};
    tbl[1] = '{vals: shl8(b_mix), dly_n: 4, dly: 3, exp_cls: 3'd2, exp_max: 32'h0000_0A00, exp_cyc: 45};
`ifdef FC_SCHED_RELU_EN
    tbl[2] = '{vals: shl8(b_neg), dly_n: -1, dly: 0, exp_cls: 3'd0, exp_max: 32'h0000_0000, exp_cyc: 42};
`else
    tbl[2] = '{vals: shl8(b_neg), dly_n: -1, dly: 0, exp_cls: 3'd7, exp_max: 32'hFFFF_FF00, exp_cyc: 42};
`endif
    tbl[3] = '{vals: shl8(b_asc), dly_n: -1, dly: 0, exp_cls: 3'd7, exp_max: 32'h0000_0800, exp_cyc: 42};
    for (int i = 0; i < N; i++) v[i] = 32'h8000_0000;
`ifdef FC_SCHED_RELU_EN
    tbl[4] = '{vals: v, dly_n: -1, dly: 0, exp_cls: 3'd0, exp_max: 32'h0000_0000, exp_cyc: 42};
`else
    tbl[4] = '{vals: v, dly_n: -1, dly: 0, exp_cls: 3'd0, exp_max: 32'h8000_0000, exp_cyc: 42};
`endif

    // Reset.
    repeat (3) step();
    check_all_zero("reset");
    i_rst = 1'b0;
    step();
    check("post_reset_busy", 32'(o_busy), 32'd0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) fetch_delay[i] = (i == tbl[t].dly_n) ? tbl[t].dly : 0;
      run_pass($sformatf("tbl%0d", t), tbl[t].vals, 2, 1'b0, tbl[t].exp_cls,
               tbl[t].exp_max, tbl[t].exp_cyc);
    end
    last_cls = tbl[4].exp_cls;
    last_max = tbl[4].exp_max;
    for (int i = 0; i < N; i++) fetch_delay[i] = 0;

    // Engine and parameter-store noise while idle must be ignored.
    rv0 = rv_count;
    for (int k = 0; k < 6; k++) begin
      step();
      i_fc_finished = 1'b1;
      i_fetch_valid = 1'($urandom_range(0, 1));
      check("idle_noise_busy", 32'(o_busy), 32'd0);
      check("idle_noise_class", 32'(o_class), 32'(last_cls));
      check("idle_noise_max", o_max, last_max);
    end
    step();
    check("idle_noise_results", 32'(rv_count), 32'(rv0));

    // Engine hangs on neuron 1: abort after the wait budget.
    setup_pass(shl8(b_mix), 2, 1);
    hang_n  = 1;
    i_start = 1'b1;
    cyc     = 1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (!o_busy) break;
    end
    check("timeout_idle", 32'(o_busy), 32'd0);
    check("timeout_error", 32'(o_error), 32'd1);
    check("timeout_wait_cycles", 32'(cyc - start1_cyc), 32'd16);
    check("timeout_no_done", 32'(done_count), 32'd0);
    check("timeout_results", 32'(rv_count), 32'd1);
    repeat (2) step();
    check("timeout_error_sticky", 32'(o_error), 32'd1);
    hang_n = -1;
    run_pass("recover", shl8(b_mix), 2, 1'b0, 3'd2, 32'h0000_0A00, 42);

    // Reset pulsed while neuron 5 is in WAIT.
    setup_pass(shl8(b_asc), 2, N);
    i_start = 1'b1;
    cyc     = 1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (o_fc_start && o_neuron_idx == 3'd5) break;
    end
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_all_zero("midreset");
    check("midreset_results_before", 32'(rv_count), 32'd5);
    exp_q.delete();
    eng_cnt = -1;
    rv0 = rv_count;
    dc0 = done_count;
    repeat (5) step();
    check("midreset_quiet_results", 32'(rv_count), 32'(rv0));
    check("midreset_quiet_done", 32'(done_count), 32'(dc0));
    check("midreset_quiet_busy", 32'(o_busy), 32'd0);

    // Fresh pass with i_start hammered while busy.
    run_pass("spam", shl8(b_mix), 2, 1'b1, 3'd2, 32'h0000_0A00, 42);

    // Random passes against the reference model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        if (r % 2 == 0) v[i] = $urandom();
        else            v[i] = 32'(($signed(32'($urandom_range(0, 6))) - 3) * 256);
        fetch_delay[i] = $urandom_range(0, 3);
      end
      eng_lat = $urandom_range(1, 4);
      ref_argmax(v, mc, mm);
      ecyc = 2;
      for (int i = 0; i < N; i++) ecyc += 3 + fetch_delay[i] + eng_lat;
      run_pass($sformatf("rand%0d", r), v, eng_lat, 1'(r % 3 == 0), mc, mm, ecyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound in case a wait is ever left unbounded.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=finished", cyc);
    $fatal(1, "simulation time bound reached");
  end

endmodule

// File: doc/fc_layer_sched.md
Name: fc_layer_sched

Overview:
- Sequences one shared FC neuron engine across all N_OUT output neurons of a layer. The engine is a single 30-input MAC unit with a start/finished handshake.
- Per neuron: requests the weight row and bias from the parameter store, pulses the engine start, then captures the 32-bit result.
- Streams each per-neuron result out and tracks a running signed argmax, so the top level gets a classification index.

Parameters:
- N_OUT, 8, number of output neurons (classes) processed per layer pass; must be >= 2.
- IDX_W, 3, width of neuron index; must satisfy 2**IDX_W >= N_OUT.
- TIMEOUT_CYC, 15, maximum cycles spent in WAIT before aborting.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  begin layer pass; sampled in IDLE only.
- o_busy  output  1  high in every state except IDLE.
- o_fetch_req  output  1  request weight row/bias for o_neuron_idx; high throughout FETCH.
- o_neuron_idx  output  IDX_W  current neuron (parameter-store row select).
- i_fetch_valid  input  1  parameter store: weights/bias for o_neuron_idx are stable on engine inputs.
- o_fc_start  output  1  one-cycle start pulse to the FC engine.
- i_fc_finished  input  1  engine result-valid pulse.
- i_fc_output  input  32  engine result, signed, Q24.8.
- o_result_valid  output  1  one-cycle pulse per neuron result.
- o_result_idx  output  IDX_W  index of the streamed result.
- o_result_data  output  32  streamed result, signed.
- o_done  output  1  one-cycle pulse when the layer pass completes.
- o_class  output  IDX_W  argmax index; held from DONE until the next accepted i_start.
- o_max  output  32  signed maximum value; held with o_class.
- o_error  output  1  set on timeout; sticky until the next accepted i_start or reset.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state goes to IDLE.
  - All outputs and internal registers go to 0.
  - Reset mid-pass aborts immediately; no o_done and no o_result_valid are emitted.
- States: IDLE, FETCH, START, WAIT, STORE, DONE.
- IDLE:
  - If i_start: idx<=0, max<=0x80000000 (most negative), class<=0, o_error<=0, next state FETCH.
  - o_class and o_max are not cleared until i_start is accepted.
- FETCH:
  - o_fetch_req=1.
  - Stay in FETCH until i_fetch_valid=1, then go to START. Minimum dwell is 1 cycle.
- START:
  - o_fc_start=1 for exactly this one cycle; next state WAIT.
  - Wait counter is cleared.
- WAIT:
  - On i_fc_finished=1: register i_fc_output into a result register, then go to STORE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC: o_error<=1, go to IDLE, no o_done.
  - Nominal engine latency is 2 cycles after the start pulse.
- STORE, one cycle:
  - o_result_valid=1, o_result_idx=idx, o_result_data=result.
  - If result > max (signed, strict): max<=result, class<=idx. Ties keep the lower index.
  - If idx==N_OUT-1 go to DONE; else idx<=idx+1 and go to FETCH.
- DONE:
  - o_done=1 for one cycle; o_class and o_max are updated and valid in this cycle.
  - Next state IDLE.
- Ignored inputs:
  - i_start outside IDLE (including in the DONE cycle).
  - i_fetch_valid outside FETCH.
  - i_fc_finished outside WAIT.
- Minimum pass latency: i_start to o_done = 1 + N_OUT*(FETCH 1 + START 1 + WAIT 2 + STORE 1) + 1 cycles. This is 42 cycles for N_OUT=8 with zero-wait fetch.
- o_neuron_idx equals idx and is stable from FETCH through STORE of each neuron.

Optional Feature:
- Macro FC_SCHED_RELU_EN.
- When defined: in WAIT, a negative i_fc_output (bit 31 set) is stored as 0. The streamed o_result_data and the argmax both see the clamped value. An all-negative layer therefore gives o_class=0, o_max=0.
- When undefined: raw signed values pass through, and argmax operates on signed results.

Test Plan:
- Zero-wait fetch, engine returns {-5,3,10,10,-1,7,2,0}<<8 -> eight o_result_valid pulses idx 0..7 with matching data; o_done at cycle 42 after i_start; o_class=2, o_max=0x00000A00 (tie with idx 3 keeps 2).
- i_fetch_valid delayed 3 cycles for neuron 4 -> o_fetch_req held 3 extra cycles, o_neuron_idx=4 stable; o_done 3 cycles later than nominal; results unchanged.
- All outputs negative {-8..-1}<<8 -> without the macro o_class=7, o_max=0xFFFFFF00; with FC_SCHED_RELU_EN o_class=0, o_max=0 and all streamed data 0.
- Engine never asserts i_fc_finished for neuron 1 -> o_error=1 after 15 WAIT cycles, state IDLE, no o_done; the next i_start clears o_error and completes normally.
- i_rst pulsed during WAIT of neuron 5 -> next cycle all outputs 0, o_busy=0; i_start pulses during the busy phase of a fresh pass are ignored (single o_done).
- i_fc_finished and i_fetch_valid pulses injected while IDLE -> no state change, no o_result_valid.
